// File: rtl/batch_engine_ctrl_pkg.sv
// batch_ctrl_pkg: shared types and helpers for the batch engine controller.
//
// Contents:
//   state_t      - 3-bit controller state encoding
//   clamp_items  - folds a requested item count into the legal 1..max range
package batch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        START    = 3'd2,
        WAIT_ENG = 3'd3,
        WRITE    = 3'd4,
        SHIFT    = 3'd5,
        ERR      = 3'd6
    } state_t;

    // A zero request still runs one item; oversize requests saturate.
    function automatic int unsigned clamp_items(input int unsigned n,
                                                input int unsigned max_items);
        if (n == 0) begin
            return 1;
        end else if (n > max_items) begin
            return max_items;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/batch_engine_ctrl_if.sv
// batch_engine_ctrl_if: user, engine and write-port signals of the batch
// engine controller, bundled so the controller takes a single bus port.
//
// Parameter: CNT_W - width of n_items / item_idx
// Modports:
//   master - the controller (drives ld, ui_reg_ld, eng_start, sh_en, wr_req,
//            done, busy, item_idx, timeout_err)
//   slave  - the surrounding user/engine/write logic (drives start, n_items,
//            eng_done, wr_ack)
interface batch_engine_ctrl_if #(
    parameter int CNT_W = 3
);

    logic             start;
    logic [CNT_W-1:0] n_items;
    logic             eng_done;
    logic             wr_ack;
    logic             ld;
    logic             ui_reg_ld;
    logic             eng_start;
    logic             sh_en;
    logic             wr_req;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] item_idx;
    logic             timeout_err;

    modport master (
        input  start, n_items, eng_done, wr_ack,
        output ld, ui_reg_ld, eng_start, sh_en, wr_req, done, busy,
               item_idx, timeout_err
    );

    modport slave (
        output start, n_items, eng_done, wr_ack,
        input  ld, ui_reg_ld, eng_start, sh_en, wr_req, done, busy,
               item_idx, timeout_err
    );

endinterface

// File: rtl/batch_engine_ctrl_eng_watchdog.sv
// eng_watchdog: counts cycles spent waiting on the engine and flags the
// cycle on which the wait reaches TIMEOUT_CYC.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clear    - restart the count (asserted the cycle before waiting begins)
//   en       - count this cycle (asserted while waiting on the engine)
//   expired  - this enabled cycle is the TIMEOUT_CYC-th waiting cycle
module eng_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Count saturates at the limit so a long stall never wraps around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TIMEOUT_CYC))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of waiting cycles already completed, so the
    // limit is hit on the cycle where cnt is one short of it.
    assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/batch_engine_ctrl.sv
// batch_engine_ctrl: sequences the load -> compute -> write -> shift
// datapath once per item for a user-programmed batch length.
//
// Optional feature macro: ENG_TIMEOUT_EN
//   defined   - engine watchdog; a stall of TIMEOUT_CYC cycles in WAIT_ENG
//               enters ERR and raises the sticky timeout_err
//   undefined - WAIT_ENG waits indefinitely, timeout_err is tied low
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous, active-high reset
//   bus       - batch_engine_ctrl_if.master:
//     in : start (level, batch begins on release), n_items (sampled on
//          IDLE->ARM), eng_done (WAIT_ENG only), wr_ack (WRITE only)
//     out: ld, ui_reg_ld, eng_start, sh_en, wr_req, done, busy, item_idx,
//          timeout_err
module batch_engine_ctrl
    import batch_ctrl_pkg::*;
#(
    parameter int MAX_ITEMS   = 4,
    parameter int CNT_W       = $clog2(MAX_ITEMS) + 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    batch_engine_ctrl_if.master    bus
);

    state_t           ps;
    state_t           ns;
    logic [CNT_W-1:0] n_latched;
    logic [CNT_W-1:0] item_idx_q;
    logic             last_item;
    logic             wd_expired;

    logic             ld_c;
    logic             ui_reg_ld_c;
    logic             eng_start_c;
    logic             sh_en_c;
    logic             wr_req_c;
    logic             done_c;
    logic             timeout_err_c;

    assign last_item = (item_idx_q == (n_latched - 1'b1));

`ifdef ENG_TIMEOUT_EN
    // START is the only way into WAIT_ENG, so it doubles as the clear.
    eng_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_eng_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (ps == START),
        .en      (ps == WAIT_ENG),
        .expired (wd_expired)
    );
`else
    // No watchdog: the expression is constant zero but still references
    // TIMEOUT_CYC so both builds share one parameter list.
    assign wd_expired = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps <= IDLE;
        end else begin
            ps <= ns;
        end
    end

    // Batch length and progress index. The count is latched once on the
    // IDLE->ARM edge; item_idx keeps its final value in IDLE for software.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_latched  <= CNT_W'(1);
            item_idx_q <= '0;
        end else begin
            if ((ps == IDLE) && bus.start) begin
                n_latched  <= CNT_W'(clamp_items(32'(bus.n_items), MAX_ITEMS));
                item_idx_q <= '0;
            end else if ((ps == WRITE) && bus.wr_ack && !last_item) begin
                item_idx_q <= item_idx_q + 1'b1;
            end
        end
    end

    // Next-state logic. Each state looks only at its own input, so stray
    // eng_done / wr_ack / start pulses elsewhere have no effect.
    always_comb begin
        ns = ps;
        case (ps)
            IDLE: begin
                if (bus.start) begin
                    ns = ARM;
                end
            end
            ARM: begin
                if (!bus.start) begin
                    ns = START;
                end
            end
            START: begin
                ns = WAIT_ENG;
            end
            WAIT_ENG: begin
                if (bus.eng_done) begin
                    ns = WRITE;
                end else if (wd_expired) begin
                    ns = ERR;
                end
            end
            WRITE: begin
                if (bus.wr_ack) begin
                    ns = last_item ? IDLE : SHIFT;
                end
            end
            SHIFT: begin
                ns = START;
            end
            ERR: begin
                if (bus.start) begin
                    ns = IDLE;
                end
            end
            default: begin
                ns = IDLE;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        ld_c          = 1'b0;
        ui_reg_ld_c   = 1'b0;
        eng_start_c   = 1'b0;
        sh_en_c       = 1'b0;
        wr_req_c      = 1'b0;
        done_c        = 1'b0;
        timeout_err_c = 1'b0;
        case (ps)
            IDLE: begin
                done_c = 1'b1;
            end
            ARM: begin
                ld_c        = 1'b1;
                ui_reg_ld_c = 1'b1;
            end
            START: begin
                eng_start_c = 1'b1;
            end
            WRITE: begin
                wr_req_c = 1'b1;
            end
            SHIFT: begin
                sh_en_c = 1'b1;
            end
            ERR: begin
`ifdef ENG_TIMEOUT_EN
                timeout_err_c = 1'b1;
`endif
            end
            default: begin
                done_c = 1'b0;
            end
        endcase
    end

    assign bus.ld          = ld_c;
    assign bus.ui_reg_ld   = ui_reg_ld_c;
    assign bus.eng_start   = eng_start_c;
    assign bus.sh_en       = sh_en_c;
    assign bus.wr_req      = wr_req_c;
    assign bus.done        = done_c;
    assign bus.timeout_err = timeout_err_c;
    assign bus.busy        = !done_c && !timeout_err_c;
    assign bus.item_idx    = item_idx_q;

endmodule

// File: tb/tb_batch_engine_ctrl.sv
// tb_batch_engine_ctrl: scoreboard bench for batch_engine_ctrl.
// Stimulus pushes the expected output events; a negedge monitor pops and
// compares each event the DUT presents (kind, item_idx, full output
// vector, cycles since the previous event). Build with +define+ENG_TIMEOUT_EN
// to also exercise the watchdog (TIMEOUT_CYC=8).
module tb_batch_engine_ctrl;

    localparam int MAX_ITEMS   = 4;
    localparam int CNT_W       = 3;
    localparam int TIMEOUT_CYC = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    batch_engine_ctrl_if #(.CNT_W(CNT_W)) bus();

    batch_engine_ctrl #(
        .MAX_ITEMS   (MAX_ITEMS),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {EV_LD, EV_START, EV_WRREQ, EV_SHIFT, EV_DONE, EV_TERR} ev_kind_t;

    typedef struct {
        ev_kind_t         kind;
        logic [CNT_W-1:0] idx;
        logic [7:0]       outs;
        int               gap;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    int  eng_delay = 0;
    int  ack_delay = 0;

    // Output vector order: {ld, ui_reg_ld, eng_start, sh_en, wr_req, done, busy, timeout_err}
    function automatic logic [7:0] outsFor(input ev_kind_t k);
        case (k)
            EV_LD:    return 8'b1100_0010;
            EV_START: return 8'b0010_0010;
            EV_WRREQ: return 8'b0000_1010;
            EV_SHIFT: return 8'b0001_0010;
            EV_DONE:  return 8'b0000_0100;
            default:  return 8'b0000_0001;
        endcase
    endfunction

    task automatic pushEv(input ev_kind_t k, input int idx, input int gap);
        ev_t e;
        e.kind = k;
        e.idx  = CNT_W'(idx);
        e.outs = outsFor(k);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Expected trace of a batch that completes normally. gap 0 = don't care.
    task automatic pushBatch(input int n_eff, input int hold, input int wr_gap,
                             input int wr_cycles);
        for (int h = 0; h < hold; h++) pushEv(EV_LD, 0, (h == 0) ? 0 : 1);
        for (int i = 0; i < n_eff; i++) begin
            pushEv(EV_START, i, 1);
            for (int w = 0; w < wr_cycles; w++) pushEv(EV_WRREQ, i, (w == 0) ? wr_gap : 1);
            if (i < n_eff - 1) pushEv(EV_SHIFT, i + 1, 1);
        end
        pushEv(EV_DONE, n_eff - 1, 1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: classify this cycle's outputs and check against the scoreboard.
    int       since_last = 0;
    logic     prev_done  = 1'b1;
    logic     prev_terr  = 1'b0;
    always @(negedge clk) begin
        logic [7:0] o;
        ev_kind_t   k;
        bit         hit;
        ev_t        e;
        o = {bus.ld, bus.ui_reg_ld, bus.eng_start, bus.sh_en, bus.wr_req,
             bus.done, bus.busy, bus.timeout_err};
        since_last++;
        hit = 1'b1;
        k   = EV_LD;
        if (bus.ld || bus.ui_reg_ld)             k = EV_LD;
        else if (bus.eng_start)                  k = EV_START;
        else if (bus.wr_req)                     k = EV_WRREQ;
        else if (bus.sh_en)                      k = EV_SHIFT;
        else if (bus.done && !prev_done)         k = EV_DONE;
        else if (bus.timeout_err && !prev_terr)  k = EV_TERR;
        else                                     hit = 1'b0;
        if (mon_en && !rst && hit) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_event: got %s idx=%0d outs=%b, expected no event",
                         k.name(), bus.item_idx, o);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || o !== e.outs || bus.item_idx !== e.idx ||
                    (e.gap != 0 && since_last != e.gap)) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_event: got %s idx=%0d outs=%b gap=%0d, expected %s idx=%0d outs=%b gap=%0d",
                             k.name(), bus.item_idx, o, since_last,
                             e.kind.name(), e.idx, e.outs, e.gap);
                end
            end
        end
        if (hit) since_last = 0;
        prev_done = bus.done;
        prev_terr = bus.timeout_err;
    end

    // Engine / write-port responder. eng_done is visible at the end of
    // WAIT_ENG cycle j when j >= eng_delay (0 also drives it during START);
    // wr_req is held for ack_delay+1 cycles.
    int ecnt = 0;
    int acnt = 0;
    bit waiting = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            waiting      = 1'b0;
            ecnt         = 0;
            acnt         = 0;
            bus.eng_done = 1'b0;
            bus.wr_ack   = 1'b0;
        end else begin
            if (bus.eng_start) begin
                waiting      = 1'b1;
                ecnt         = 0;
                bus.eng_done = (eng_delay == 0);
            end else if (waiting && !bus.wr_req && !bus.done && !bus.timeout_err) begin
                ecnt++;
                bus.eng_done = (ecnt >= eng_delay);
            end else begin
                waiting      = 1'b0;
                bus.eng_done = 1'b0;
            end
            if (bus.wr_req) begin
                acnt++;
                bus.wr_ack = (acnt > ack_delay);
            end else begin
                acnt       = 0;
                bus.wr_ack = 1'b0;
            end
        end
    end

    // Hold start for 'hold' cycles, change n_items right after it is latched,
    // optionally re-assert start during the first item.
    task automatic applyStimulus(input int n_req, input int hold, input int n_after,
                                 input bit intrude);
        @(negedge clk);
        bus.n_items = CNT_W'(n_req);
        bus.start   = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == 0) bus.n_items = CNT_W'(n_after);
        end
        bus.start = 1'b0;
        if (intrude) begin
            for (int c = 0; c < 50 && !bus.eng_start; c++) @(negedge clk);
            bus.start = 1'b1;
            repeat (3) @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.n_items = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset_done", 32'(bus.done), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_strobes", 32'({bus.ld, bus.ui_reg_ld, bus.eng_start, bus.sh_en, bus.wr_req}), 32'd0);
        checkOutput("reset_item_idx", 32'(bus.item_idx), 32'd0);
        checkOutput("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_done", 32'(bus.done), 32'd1);
        mon_en = 1'b1;

        // n=3, start held 3 cycles, immediate responses, start poked mid-batch
        eng_delay = 0;
        ack_delay = 0;
        pushBatch(3, 3, 2, 1);
        applyStimulus(3, 3, 1, 1'b1);
        waitDrain();
        checkOutput("n3_done", 32'(bus.done), 32'd1);
        checkOutput("n3_idx_hold", 32'(bus.item_idx), 32'd2);

        // n=0 runs one item
        pushBatch(1, 2, 2, 1);
        applyStimulus(0, 2, 3, 1'b0);
        waitDrain();
        checkOutput("n0_idx_hold", 32'(bus.item_idx), 32'd0);

        // n=7 saturates at MAX_ITEMS=4
        pushBatch(4, 1, 2, 1);
        applyStimulus(7, 1, 1, 1'b0);
        waitDrain();
        checkOutput("n7_idx_hold", 32'(bus.item_idx), 32'd3);

        // wr_ack delayed 5 cycles: wr_req held 6 cycles per item
        ack_delay = 5;
        pushBatch(2, 2, 2, 6);
        applyStimulus(2, 2, 2, 1'b0);
        waitDrain();
        checkOutput("slow_ack_idx_hold", 32'(bus.item_idx), 32'd1);
        ack_delay = 0;

`ifdef ENG_TIMEOUT_EN
        // Engine never answers: ERR after 8 WAIT_ENG cycles
        eng_delay = 1000;
        pushEv(EV_LD, 0, 0);
        pushEv(EV_START, 0, 1);
        pushEv(EV_TERR, 0, TIMEOUT_CYC + 1);
        applyStimulus(1, 1, 1, 1'b0);
        waitDrain();
        checkOutput("err_timeout_err", 32'(bus.timeout_err), 32'd1);
        checkOutput("err_busy", 32'(bus.busy), 32'd0);
        checkOutput("err_done", 32'(bus.done), 32'd0);
        pushEv(EV_DONE, 0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDrain();
        checkOutput("err_cleared", 32'(bus.timeout_err), 32'd0);

        // eng_done on the limit cycle wins
        eng_delay = TIMEOUT_CYC;
        pushBatch(1, 1, TIMEOUT_CYC + 1, 1);
        applyStimulus(1, 1, 1, 1'b0);
        waitDrain();
        checkOutput("limit_no_err", 32'(bus.timeout_err), 32'd0);
        eng_delay = 0;
`endif

        // Reset in the middle of the second item's WRITE
        mon_en    = 1'b0;
        ack_delay = 0;
        applyStimulus(2, 1, 2, 1'b0);
        for (int c = 0; c < 50 && !bus.sh_en; c++) @(negedge clk);
        ack_delay = 1000;
        for (int c = 0; c < 50 && !bus.wr_req; c++) @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_wr_req", 32'(bus.wr_req), 32'd1);
        checkOutput("pre_rst_idx", 32'(bus.item_idx), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_done", 32'(bus.done), 32'd1);
        checkOutput("async_rst_wr_req", 32'(bus.wr_req), 32'd0);
        checkOutput("async_rst_idx", 32'(bus.item_idx), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        checkOutput("post_rst_done", 32'(bus.done), 32'd1);
        checkOutput("post_rst_wr_req", 32'(bus.wr_req), 32'd0);
        checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
